layer_feeder: RTL and testbench

//  Drives one fully-parallel node: collects a serial stream of activations into NUM_IN

---
 rtl/layer_feeder.sv | 133 +++++++++++++
 tb/tb_layer_feeder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_feeder.sv
// layer_feeder
//   Feeds one fully-parallel node. A serial activation stream is collected into
//   NUM_IN shadow slots. When the last slot of a frame arrives, all slots are
//   copied at once onto the packed operand bus, so the node never sees a partial
//   frame. The feeder then waits out the node latency, captures the node result
//   and returns it on a valid/ready stream. The next frame is accepted only after
//   that result has been taken.
//
//   Optional macro: FEEDER_SIGNEXT_EN
//     defined   -> activations are sign-extended to AW bits in each slot
//     undefined -> activations are zero-extended (default)
//
// Ports
//   clk      in   1          clock, all logic on posedge
//   reset    in   1          synchronous, active-low
//   s_data   in   DW         incoming activation
//   s_valid  in   1          s_data valid
//   s_ready  out  1          feeder accepts s_data (FILL only)
//   a_bus    out  NUM_IN*AW  node operands, slot k = a_bus[k*AW +: AW]
//   n_in     in   AW         node result (low DW bits used)
//   m_data   out  DW         captured node result
//   m_valid  out  1          m_data valid
//   m_ready  in   1          downstream accepts m_data
module layer_feeder #(
   parameter int NUM_IN  = 15,
   parameter int DW      = 8,
   parameter int AW      = 24,
   parameter int LATENCY = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DW-1:0]        s_data,
   input  logic                 s_valid,
   output logic                 s_ready,
   output logic [NUM_IN*AW-1:0] a_bus,
   input  logic [AW-1:0]        n_in,
   output logic [DW-1:0]        m_data,
   output logic                 m_valid,
   input  logic                 m_ready
);

   localparam int CW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
   localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {FILL, HOLD, RESULT} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic [LW-1:0]   lat;
   logic [AW-1:0]   shadow [NUM_IN];
   logic            accept;
   logic            last_word;
   logic            lat_done;
   logic            take;
   logic            n_in_unused;

   // Activation to slot-width conversion.
   function automatic logic [AW-1:0] extend(input logic [DW-1:0] d);
`ifdef FEEDER_SIGNEXT_EN
      return {{(AW-DW){d[DW-1]}}, d};
`else
      return {{(AW-DW){1'b0}}, d};
`endif
   endfunction

   // Only the low DW bits of the node result are returned.
   assign n_in_unused = ^n_in[AW-1:DW];

   assign accept    = s_valid && s_ready && (state == FILL);
   assign last_word = (cnt == CW'(NUM_IN - 1));
   assign lat_done  = (lat == LW'(LATENCY - 1));
   assign take      = (state == RESULT) && m_valid && m_ready;

   always_ff @(posedge clk) begin
      if (!reset) state <= FILL;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FILL:    if (accept && last_word) state_nxt = HOLD;
         HOLD:    if (lat_done)            state_nxt = RESULT;
         RESULT:  if (take)                state_nxt = FILL;
         default:                          state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt     <= '0;
         lat     <= '0;
         s_ready <= 1'b0;
         m_valid <= 1'b0;
         m_data  <= '0;
         a_bus   <= '0;
         for (int k = 0; k < NUM_IN; k++) shadow[k] <= '0;
      end else begin
         // s_ready is registered from the next state, so it drops on the edge
         // that completes a frame and rises the cycle after a result is taken.
         s_ready <= (state_nxt == FILL);

         if (accept) begin
            shadow[cnt] <= extend(s_data);
            if (last_word) begin
               // The final word bypasses the shadow so the whole frame lands
               // on a_bus in a single edge.
               for (int k = 0; k < NUM_IN; k++) begin
                  if (k == NUM_IN - 1) a_bus[k*AW +: AW] <= extend(s_data);
                  else                 a_bus[k*AW +: AW] <= shadow[k];
               end
               cnt <= '0;
               lat <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end

         // n_in is sampled exactly LATENCY edges after a_bus changed.
         if (state == HOLD) begin
            if (lat_done) begin
               m_data  <= n_in[DW-1:0];
               m_valid <= 1'b1;
            end else begin
               lat <= lat + 1'b1;
            end
         end

         if (take) m_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_layer_feeder.sv
module tb_layer_feeder;

   localparam int NUM_IN  = 15;
   localparam int DW      = 8;
   localparam int AW      = 24;
   localparam int LATENCY = 3;
   localparam int BW      = NUM_IN * AW;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic [BW-1:0] a_bus;
   logic [AW-1:0] n_in;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;

   always #5 clk = ~clk;

   layer_feeder #(
      .NUM_IN(NUM_IN), .DW(DW), .AW(AW), .LATENCY(LATENCY)
   ) dut (
      .clk(clk), .reset(reset),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .a_bus(a_bus), .n_in(n_in),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
   );

   // Node stub: weights 1..NUM_IN on slots 0..NUM_IN-1; combinational sum
   // followed by LATENCY-1 registers, so the result for a new operand bus is
   // present just before the LATENCY-th edge after the bus changed.
   logic [AW-1:0] node_sum, node_p1, node_p2;
   always_comb begin
      node_sum = '0;
      for (int k = 0; k < NUM_IN; k++)
         node_sum = node_sum + AW'(AW'(k + 1) * a_bus[k*AW +: AW]);
   end
   always @(posedge clk) begin
      node_p1 <= node_sum;
      node_p2 <= node_p1;
   end
   assign n_in = node_p2;

   int            checks = 0;
   int            passed = 0;
   int            cyc = 0;
   int            n_results = 0;
   int            first_acc_cyc = 0;
   logic [7:0]    exp_q[$];
   int            take_cycs[$];
   logic [7:0]    w [NUM_IN];
   logic [BW-1:0] prev_bus;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [AW-1:0] ext8(input logic [7:0] d);
`ifdef FEEDER_SIGNEXT_EN
      return {{16{d[7]}}, d};
`else
      return {16'h0000, d};
`endif
   endfunction

   function automatic logic [7:0] exp_result(input logic [7:0] wv [NUM_IN]);
      logic [AW-1:0] s;
      s = '0;
      for (int k = 0; k < NUM_IN; k++) s = s + AW'(AW'(k + 1) * ext8(wv[k]));
      return s[7:0];
   endfunction

   // Scoreboard monitor: one pop per output handshake.
   always @(negedge clk) begin
      if (reset === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_result: got %0h expected none", m_data);
         end else begin
            check("result", BW'(m_data), BW'(exp_q.pop_front()));
         end
         n_results++;
         take_cycs.push_back(cyc);
      end
   end

   task automatic do_reset();
      reset = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_a_bus",   a_bus,   '0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data",  m_data,  0);
      check("rst_s_ready", s_ready, 0);
      reset = 1'b1;
      @(posedge clk); #1;
      check("rst_s_ready_rise", s_ready, 1);
      prev_bus = '0;
   endtask

   task automatic send_word(input logic [7:0] d);
      int t;
      t = 0;
      s_data = d; s_valid = 1'b1;
      while (s_ready !== 1'b1 && t < 200) begin
         @(posedge clk); #1; t++;
      end
      if (s_ready !== 1'b1) begin
         checks++;
         $display("FAIL s_ready_timeout: got %0b expected 1", s_ready);
      end else begin
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] wv [NUM_IN], input logic [7:0] exp_res,
                             input bit gaps);
      logic [BW-1:0] eb;
      for (int i = 0; i < NUM_IN; i++) begin
         if (gaps && $urandom_range(0, 1) == 1) begin
            @(posedge clk); #1;
         end
         send_word(wv[i]);
         if (i == 0) first_acc_cyc = cyc;
         if (i < NUM_IN - 1) check("a_bus_hold", a_bus, prev_bus);
      end
      for (int k = 0; k < NUM_IN; k++) eb[k*AW +: AW] = ext8(wv[k]);
      check("a_bus_frame", a_bus, eb);
      check("s_ready_hold", s_ready, 0);
      exp_q.push_back(exp_res);
      prev_bus = eb;
   endtask

   task automatic wait_results(input int n);
      int t;
      t = 0;
      while (n_results < n && t < 100) begin
         @(posedge clk); t++;
      end
      #1;
      check("result_count", n_results, n);
   endtask

   initial begin
      int base;
      logic [7:0] r;
      reset = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
      prev_bus = '0;

      // 1: frame 1..15, result timing
      do_reset();
      m_ready = 1'b1;
      for (int i = 0; i < NUM_IN; i++) w[i] = 8'(i + 1);
      send_frame(w, 8'hD8, 1'b0);
      @(posedge clk); #1; check("t1_mvalid_e1", m_valid, 0);
      @(posedge clk); #1; check("t1_mvalid_e2", m_valid, 0);
      @(posedge clk); #1; check("t1_mvalid_e3", m_valid, 1);
      @(posedge clk); #1;
      check("t1_mvalid_taken", m_valid, 0);
      check("t1_s_ready_back", s_ready, 1);
      check("t1_results", n_results, 1);

      // 2: partial frame discarded by reset
      for (int i = 0; i < 7; i++) send_word(8'hA0 + 8'(i));
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      check("t2_a_bus_cleared", a_bus, '0);
      check("t2_s_ready_rst", s_ready, 0);
      check("t2_m_valid_rst", m_valid, 0);
      @(posedge clk); #1;
      check("t2_s_ready_rise", s_ready, 1);
      prev_bus = '0;
      for (int i = 0; i < NUM_IN; i++) w[i] = 8'h02;
      send_frame(w, 8'hF0, 1'b0);
      wait_results(2);
      repeat (5) @(posedge clk);
      #1;
      check("t2_one_result", n_results, 2);

      // 3: result held while m_ready low
      m_ready = 1'b0;
      for (int i = 0; i < NUM_IN; i++) w[i] = 8'h20 + 8'(i);
      r = exp_result(w);
      send_frame(w, r, 1'b0);
      begin
         int t;
         t = 0;
         while (m_valid !== 1'b1 && t < 20) begin
            @(posedge clk); #1; t++;
         end
      end
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         check("t3_m_valid", m_valid, 1);
         check("t3_m_data", m_data, r);
         check("t3_s_ready", s_ready, 0);
         check("t3_a_bus", a_bus, prev_bus);
      end
      m_ready = 1'b1;
      @(posedge clk); #1;
      check("t3_taken_first", m_valid, 0);
      check("t3_results", n_results, 3);

      // 4: random gaps during FILL
      for (int i = 0; i < NUM_IN; i++) w[i] = 8'h10 + 8'(3 * i);
      send_frame(w, exp_result(w), 1'b1);
      wait_results(4);

      // 5: 0xFF extension
      for (int i = 0; i < NUM_IN; i++) w[i] = 8'h00;
      w[0] = 8'hFF;
      send_frame(w, 8'hFF, 1'b0);
`ifdef FEEDER_SIGNEXT_EN
      check("t5_slot0", BW'(a_bus[AW-1:0]), BW'(24'hFFFFFF));
`else
      check("t5_slot0", BW'(a_bus[AW-1:0]), BW'(24'h0000FF));
`endif
      check("t5_slot1", BW'(a_bus[2*AW-1:AW]), BW'(24'h000000));
      wait_results(5);

      // 6: back-to-back frames, period and ordering
      base = take_cycs.size();
      for (int i = 0; i < NUM_IN; i++) w[i] = 8'h40 - 8'(i);
      send_frame(w, exp_result(w), 1'b0);
      for (int i = 0; i < NUM_IN; i++) w[i] = 8'h05 + 8'(7 * i);
      send_frame(w, exp_result(w), 1'b0);
      check("t6_frame2_after_take", first_acc_cyc, take_cycs[base] + 2);
      wait_results(7);
      if (take_cycs.size() >= base + 2)
         check("t6_period", take_cycs[base+1] - take_cycs[base], 19);
      else begin
         checks++;
         $display("FAIL t6_period: got %0d results expected 2", take_cycs.size() - base);
      end

      repeat (5) @(posedge clk);
      #1;
      check("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
